// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module  : mem_arb_pkg
//  Brief   : Shared types and constants for the external memory bus arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Bus owner identity, used for round-robin bookkeeping.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LOAD = 1'b1
  } owner_t;

  // Arbiter states; ST_TURN is the dead cycle between two owners.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_LOAD = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  // Width of the per-tenure access counter (saturates at all-ones).
  localparam int HOLD_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_busmux.sv
// ============================================================================
//  Module  : mem_arb_busmux
//  Brief   : Combinational owner select for the memory bus. Every bus output
//            and both read-data returns are forced to zero unless the granted
//            requester is actually requesting in this cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_busmux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              core_gnt_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_adr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              ld_gnt_i,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_adr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic core_acc;
  logic ld_acc;

  // Route the owner's access onto the bus; idle or non-requesting cycles drive zeros.
  always_comb begin
    core_acc     = core_gnt_i & core_req_i;
    ld_acc       = ld_gnt_i & ld_req_i;
    mem_adr_o    = '0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    core_rdata_o = '0;
    ld_rdata_o   = '0;
    if (core_acc) begin
      mem_adr_o    = core_adr_i;
      mem_we_o     = core_we_i;
      mem_wdata_o  = core_we_i ? core_wdata_i : '0;
      core_rdata_o = mem_rdata_i;
    end else if (ld_acc) begin
      mem_adr_o    = ld_adr_i;
      mem_we_o     = ld_we_i;
      mem_wdata_o  = ld_we_i ? ld_wdata_i : '0;
      ld_rdata_o   = mem_rdata_i;
    end
  end

  // Data pins are driven exactly when writing.
  assign mem_oe_o = mem_we_o;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module  : mem_bus_arbiter
//  Brief   : Round-robin arbiter with hold limit for the external memory bus,
//            shared by the core port and the boot/debug loader port. Grants
//            are registered; every owner switch passes through one TURN cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_SAT  = '1;

  state_t                state_q, state_d;
  owner_t                last_owner_q, last_owner_d;
  owner_t                next_owner_q, next_owner_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  core_gnt_q, ld_gnt_q;

  logic   cur_req;
  logic   oth_req;
  owner_t oth_owner;
  logic   enter;
  owner_t enter_owner;

  // Next-state logic, written from the current owner's point of view so CORE and LOAD share one rule.
  always_comb begin
    cur_req      = (state_q == ST_LOAD) ? ld_req : core_req;
    oth_req      = (state_q == ST_LOAD) ? core_req : ld_req;
    oth_owner    = (state_q == ST_LOAD) ? OWN_CORE : OWN_LOAD;
    state_d      = state_q;
    last_owner_d = last_owner_q;
    next_owner_d = next_owner_q;
    hold_cnt_d   = hold_cnt_q;
    enter        = 1'b0;
    enter_owner  = OWN_CORE;
    case (state_q)
      ST_IDLE: begin
        if (core_req && (!ld_req || last_owner_q == OWN_LOAD)) begin
          enter       = 1'b1;
          enter_owner = OWN_CORE;
        end else if (ld_req) begin
          enter       = 1'b1;
          enter_owner = OWN_LOAD;
        end
      end
      ST_CORE, ST_LOAD: begin
        if (cur_req && hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        end
        if (!cur_req) begin
          if (oth_req) begin
            state_d      = ST_TURN;
            next_owner_d = oth_owner;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (oth_req && hold_cnt_q >= HOLD_LAST) begin
          // ">=" so an owner that ran past the limit unopposed still yields
          // as soon as the other side starts asking.
          state_d      = ST_TURN;
          next_owner_d = oth_owner;
        end
      end
      ST_TURN: begin
        if ((next_owner_q == OWN_CORE) ? core_req : ld_req) begin
          enter       = 1'b1;
          enter_owner = next_owner_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter) begin
      state_d      = (enter_owner == OWN_CORE) ? ST_CORE : ST_LOAD;
      hold_cnt_d   = '0;
      last_owner_d = enter_owner;
    end
  end

  // FSM and bookkeeping registers; grants are registered copies of the next state.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_LOAD;
      next_owner_q <= OWN_CORE;
      hold_cnt_q   <= '0;
      core_gnt_q   <= 1'b0;
      ld_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      next_owner_q <= next_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      core_gnt_q   <= (state_d == ST_CORE);
      ld_gnt_q     <= (state_d == ST_LOAD);
    end
  end

  assign core_gnt = core_gnt_q;
  assign ld_gnt   = ld_gnt_q;

  mem_arb_busmux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_busmux (
    .core_gnt_i   (core_gnt_q),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_adr_i   (core_adr),
    .core_wdata_i (core_wdata),
    .core_rdata_o (core_rdata),
    .ld_gnt_i     (ld_gnt_q),
    .ld_req_i     (ld_req),
    .ld_we_i      (ld_we),
    .ld_adr_i     (ld_adr),
    .ld_wdata_i   (ld_wdata),
    .ld_rdata_o   (ld_rdata),
    .mem_adr_o    (mem_adr),
    .mem_we_o     (mem_we),
    .mem_oe_o     (mem_oe),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  // The two grants must never overlap.
  a_gnt_onehot : assert property (@(posedge ph1) disable iff (!reset) !(core_gnt_q && ld_gnt_q));

endmodule

`default_nettype wire
